// File: rtl/window_seq_ctrl.sv
// rtl/window_seq_ctrl.sv - 3x3 line-buffer window sequencer: feeds the buffer, flushes, and qualifies windows.
module window_seq_ctrl #(
  parameter int H_ACTIVE   = 640,
  parameter int V_ACTIVE   = 480,
  parameter int PIX_W      = 12,
  parameter int CENTER_LAG = 2*H_ACTIVE+1,
  localparam int COL_W     = $clog2(H_ACTIVE),
  localparam int ROW_W     = $clog2(V_ACTIVE)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cam_valid,
  input  logic             cam_sof,
  input  logic [PIX_W-1:0] cam_pix,
  output logic             cam_ready,
  output logic             buf_valid,
  output logic             buf_edge,
  output logic [PIX_W-1:0] buf_pix,
  output logic             win_valid,
  output logic             win_border,
  output logic [COL_W-1:0] win_col,
  output logic [ROW_W-1:0] win_row,
  output logic             frame_done,
  output logic             sync_err
);

  localparam int SHIFT_W = $clog2(CENTER_LAG+1);
  localparam logic [COL_W-1:0]   COL_LAST   = COL_W'(H_ACTIVE-1);
  localparam logic [ROW_W-1:0]   ROW_LAST   = ROW_W'(V_ACTIVE-1);
  localparam logic [SHIFT_W-1:0] LAG        = SHIFT_W'(CENTER_LAG);
  localparam logic [SHIFT_W-1:0] FLUSH_LAST = SHIFT_W'(CENTER_LAG-1);

  typedef enum logic [1:0] {S_IDLE, S_STREAM, S_FLUSH, S_DONE} state_t;

  state_t state_q, state_d;

  logic               cam_ready_q, cam_ready_d;
  logic [COL_W-1:0]   in_col_q, in_col_d;
  logic [ROW_W-1:0]   in_row_q, in_row_d;
  logic [SHIFT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic [SHIFT_W-1:0] shift_cnt_q, shift_cnt_d;
  logic [COL_W-1:0]   ctr_col_q, ctr_col_d;
  logic [ROW_W-1:0]   ctr_row_q, ctr_row_d;
  logic               buf_valid_q, buf_valid_d;
  logic               buf_edge_q, buf_edge_d;
  logic [PIX_W-1:0]   buf_pix_q, buf_pix_d;
  logic               win_valid_q, win_valid_d;
  logic               win_border_q, win_border_d;
  logic [COL_W-1:0]   win_col_q, win_col_d;
  logic [ROW_W-1:0]   win_row_q, win_row_d;
  logic               frame_done_q, frame_done_d;
  logic               sync_err_q, sync_err_d;

  logic             accept, sof_start, last_pix;
  logic [COL_W-1:0] base_col, adv_col;
  logic [ROW_W-1:0] base_row, adv_row;

  // cam_ready is only high in IDLE/STREAM, so any accepted sof beat starts a frame
  assign accept    = cam_valid && cam_ready_q;
  assign sof_start = accept && cam_sof;
  assign last_pix  = (in_col_q == COL_LAST) && (in_row_q == ROW_LAST);

  assign base_col = sof_start ? '0 : in_col_q;
  assign base_row = sof_start ? '0 : in_row_q;
  assign adv_col  = (base_col == COL_LAST) ? '0 : base_col + COL_W'(1);
  assign adv_row  = (base_col != COL_LAST) ? base_row :
                    (base_row == ROW_LAST) ? '0 : base_row + ROW_W'(1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (sof_start) state_d = S_STREAM;
      S_STREAM: if (accept && !cam_sof && last_pix) state_d = S_FLUSH;
      S_FLUSH:  if (flush_cnt_q == FLUSH_LAST) state_d = S_DONE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    cam_ready_d  = (state_d == S_IDLE) || (state_d == S_STREAM);
    in_col_d     = in_col_q;
    in_row_d     = in_row_q;
    flush_cnt_d  = '0;
    buf_valid_d  = 1'b0;
    buf_edge_d   = 1'b0;
    buf_pix_d    = '0;
    sync_err_d   = sof_start && (state_q == S_STREAM);
    shift_cnt_d  = shift_cnt_q;
    ctr_col_d    = ctr_col_q;
    ctr_row_d    = ctr_row_q;
    win_valid_d  = 1'b0;
    win_border_d = win_border_q;
    win_col_d    = win_col_q;
    win_row_d    = win_row_q;
    frame_done_d = 1'b0;

    if (sof_start || (accept && state_q == S_STREAM)) begin
      buf_valid_d = 1'b1;
      buf_pix_d   = cam_pix;
      buf_edge_d  = (base_col == '0);
      in_col_d    = adv_col;
      in_row_d    = adv_row;
    end else if (state_q == S_FLUSH) begin
      buf_valid_d = 1'b1;
      buf_edge_d  = (in_col_q == '0);
      in_col_d    = adv_col;
      in_row_d    = adv_row;
      flush_cnt_d = flush_cnt_q + SHIFT_W'(1);
    end

    // A restart discards the strobe in flight, which belongs to the aborted frame
    if (sof_start) begin
      shift_cnt_d = '0;
      ctr_col_d   = '0;
      ctr_row_d   = '0;
    end else if (buf_valid_q) begin
      if (shift_cnt_q == LAG) begin
        win_valid_d  = 1'b1;
        win_col_d    = ctr_col_q;
        win_row_d    = ctr_row_q;
        win_border_d = (ctr_row_q == '0) || (ctr_row_q == ROW_LAST) ||
                       (ctr_col_q == '0) || (ctr_col_q == COL_LAST);
        frame_done_d = (ctr_col_q == COL_LAST) && (ctr_row_q == ROW_LAST);
        ctr_col_d    = (ctr_col_q == COL_LAST) ? '0 : ctr_col_q + COL_W'(1);
        if (ctr_col_q == COL_LAST)
          ctr_row_d = (ctr_row_q == ROW_LAST) ? '0 : ctr_row_q + ROW_W'(1);
      end else begin
        shift_cnt_d = shift_cnt_q + SHIFT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cam_ready_q  <= 1'b0;
      in_col_q     <= '0;
      in_row_q     <= '0;
      flush_cnt_q  <= '0;
      shift_cnt_q  <= '0;
      ctr_col_q    <= '0;
      ctr_row_q    <= '0;
      buf_valid_q  <= 1'b0;
      buf_edge_q   <= 1'b0;
      buf_pix_q    <= '0;
      win_valid_q  <= 1'b0;
      win_border_q <= 1'b0;
      win_col_q    <= '0;
      win_row_q    <= '0;
      frame_done_q <= 1'b0;
      sync_err_q   <= 1'b0;
    end else begin
      cam_ready_q  <= cam_ready_d;
      in_col_q     <= in_col_d;
      in_row_q     <= in_row_d;
      flush_cnt_q  <= flush_cnt_d;
      shift_cnt_q  <= shift_cnt_d;
      ctr_col_q    <= ctr_col_d;
      ctr_row_q    <= ctr_row_d;
      buf_valid_q  <= buf_valid_d;
      buf_edge_q   <= buf_edge_d;
      buf_pix_q    <= buf_pix_d;
      win_valid_q  <= win_valid_d;
      win_border_q <= win_border_d;
      win_col_q    <= win_col_d;
      win_row_q    <= win_row_d;
      frame_done_q <= frame_done_d;
      sync_err_q   <= sync_err_d;
    end
  end

  assign cam_ready  = cam_ready_q;
  assign buf_valid  = buf_valid_q;
  assign buf_edge   = buf_edge_q;
  assign buf_pix    = buf_pix_q;
  assign win_valid  = win_valid_q;
  assign win_border = win_border_q;
  assign win_col    = win_col_q;
  assign win_row    = win_row_q;
  assign frame_done = frame_done_q;
  assign sync_err   = sync_err_q;

endmodule

// File: tb/tb_window_seq_ctrl.sv
// tb/tb_window_seq_ctrl.sv - randomized bench for window_seq_ctrl against a per-frame arithmetic model.
module tb_window_seq_ctrl;

  localparam int H  = 4;
  localparam int V  = 3;
  localparam int PW = 12;
  localparam int CL = 9;

  logic          clk = 0;
  logic          rst = 0;
  logic          cam_valid = 0;
  logic          cam_sof = 0;
  logic [PW-1:0] cam_pix = 0;
  logic          cam_ready, buf_valid, buf_edge, win_valid, win_border, frame_done, sync_err;
  logic [PW-1:0] buf_pix;
  logic [1:0]    win_col, win_row;

  window_seq_ctrl #(.H_ACTIVE(H), .V_ACTIVE(V), .PIX_W(PW), .CENTER_LAG(CL)) dut (
    .clk(clk), .rst(rst), .cam_valid(cam_valid), .cam_sof(cam_sof), .cam_pix(cam_pix),
    .cam_ready(cam_ready), .buf_valid(buf_valid), .buf_edge(buf_edge), .buf_pix(buf_pix),
    .win_valid(win_valid), .win_border(win_border), .win_col(win_col), .win_row(win_row),
    .frame_done(frame_done), .sync_err(sync_err)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  // Model: mode 0 idle, 1 stream, 2 flush, 3 done; windows derived from the frame strobe count
  int m_mode = 0, m_npix = 0, m_nflush = 0, m_strobes = 0;
  bit m_ready = 0;
  bit e_bv = 0, e_edge = 0, e_wv = 0, e_border = 0, e_fd = 0, e_sync = 0;
  int e_pix = 0, e_row = 0, e_col = 0;

  initial forever begin
    @(posedge clk or negedge rst);
    if (!rst) begin
      m_mode = 0; m_npix = 0; m_nflush = 0; m_strobes = 0; m_ready = 0;
      e_bv = 0; e_edge = 0; e_wv = 0; e_border = 0; e_fd = 0; e_sync = 0; e_pix = 0;
    end else begin
      bit acc, restart;
      int idx;
      acc     = cam_valid && m_ready;
      restart = acc && cam_sof;
      e_wv = 0; e_fd = 0; e_sync = 0;
      if (restart) m_strobes = 0;
      else if (e_bv) begin
        m_strobes++;
        if (m_strobes > CL) begin
          idx      = m_strobes - CL - 1;
          e_wv     = 1;
          e_row    = idx / H;
          e_col    = idx % H;
          e_border = (e_row == 0) || (e_row == V-1) || (e_col == 0) || (e_col == H-1);
          e_fd     = (idx == H*V-1);
        end
      end
      e_bv = 0; e_edge = 0; e_pix = 0;
      case (m_mode)
        0: if (restart) begin
          e_bv = 1; e_pix = int'(cam_pix); e_edge = 1; m_npix = 1; m_mode = 1;
        end
        1: if (acc) begin
          if (cam_sof) begin e_sync = 1; m_npix = 0; end
          e_bv = 1; e_pix = int'(cam_pix); e_edge = (m_npix % H == 0);
          m_npix++;
          if (m_npix == H*V) begin m_mode = 2; m_nflush = 0; end
        end
        2: begin
          e_bv = 1; e_edge = (m_npix % H == 0); m_npix++; m_nflush++;
          if (m_nflush == CL) m_mode = 3;
        end
        default: m_mode = 0;
      endcase
      m_ready = (m_mode < 2);
    end
  end

  // Observation tallies per scenario, compared to hand-derived constants
  int t_bv, t_wv, t_fd, t_sync, t_rdy_low, t_strobe, t_run, t_maxrun, t_nonborder, t_fd_at;
  int t_first, t_last;
  logic [31:0] t_edge_mask;

  task automatic clear_tally();
    t_bv = 0; t_wv = 0; t_fd = 0; t_sync = 0; t_rdy_low = 0; t_strobe = 0; t_run = 0;
    t_maxrun = 0; t_nonborder = 0; t_fd_at = 0; t_first = -1; t_last = -1; t_edge_mask = 0;
  endtask

  initial begin
    clear_tally();
    forever begin
      @(negedge clk);
      chk("cam_ready", int'(cam_ready), int'(m_ready));
      chk("buf_valid", int'(buf_valid), int'(e_bv));
      chk("win_valid", int'(win_valid), int'(e_wv));
      chk("frame_done", int'(frame_done), int'(e_fd));
      chk("sync_err", int'(sync_err), int'(e_sync));
      if (e_bv) begin
        chk("buf_edge", int'(buf_edge), int'(e_edge));
        chk("buf_pix", int'(buf_pix), e_pix);
      end
      if (e_wv) begin
        chk("win_row", int'(win_row), e_row);
        chk("win_col", int'(win_col), e_col);
        chk("win_border", int'(win_border), int'(e_border));
      end
      if (!cam_ready) t_rdy_low++;
      if (sync_err) t_sync++;
      if (buf_valid) begin
        t_bv++; t_strobe++; t_run++;
        if (t_run > t_maxrun) t_maxrun = t_run;
        if (buf_edge && t_strobe < 32) t_edge_mask[t_strobe] = 1'b1;
      end else t_run = 0;
      if (win_valid) begin
        if (t_wv == 0) t_first = int'({win_row, win_col});
        t_last = int'({win_row, win_col});
        if (!win_border) t_nonborder++;
        t_wv++;
        if (frame_done) begin t_fd++; t_fd_at = t_wv; end
      end
    end
  end

  task automatic beat(input logic v, input logic s);
    @(posedge clk);
    #1;
    cam_valid = v;
    cam_sof   = s;
    cam_pix   = PW'($urandom);
  endtask

  task automatic idle(input int n);
    repeat (n) beat(1'b0, 1'b0);
  endtask

  task automatic frame_checks(input string tag);
    chk({tag, "_wv_count"}, t_wv, 12);
    chk({tag, "_first_rc"}, t_first, 0);
    chk({tag, "_last_rc"}, t_last, 4'b1011);
    chk({tag, "_fd_count"}, t_fd, 1);
    chk({tag, "_fd_on_12th"}, t_fd_at, 12);
  endtask

  initial begin
    int acc;
    bit v;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", int'(cam_ready), 0);
    chk("rst_bv", int'(buf_valid), 0);
    chk("rst_wv", int'(win_valid), 0);
    @(negedge clk);
    rst = 1;
    idle(3);

    // Continuous frame with cam_valid held high throughout
    clear_tally();
    beat(1, 1);
    repeat (21) beat(1, 0);
    idle(8);
    frame_checks("cont");
    chk("cont_bv_total", t_bv, 21);
    chk("cont_bv_run", t_maxrun, 21);
    chk("cont_nonborder", t_nonborder, 2);
    chk("cont_edge_mask", int'(t_edge_mask), 32'h0022_2222);
    chk("cont_ready_low", t_rdy_low, 10);
    chk("cont_sync", t_sync, 0);

    // Toggling cam_valid
    clear_tally();
    beat(1, 1);
    repeat (11) begin beat(0, 0); beat(1, 0); end
    idle(25);
    frame_checks("toggle");
    chk("toggle_bv_total", t_bv, 21);

    // Beats without sof while idle are dropped
    clear_tally();
    repeat (5) beat(1, 0);
    idle(3);
    chk("nosof_bv", t_bv, 0);
    chk("nosof_wv", t_wv, 0);

    // Random gaps
    for (int f = 0; f < 3; f++) begin
      clear_tally();
      beat(1, 1);
      acc = 1;
      for (int c = 0; c < 200 && acc < 12; c++) begin
        v = 1'($urandom_range(0, 1));
        beat(v, 1'b0);
        if (v) acc++;
      end
      idle(25);
      frame_checks("rand");
    end

    // sof on the 7th beat restarts the frame
    clear_tally();
    beat(1, 1);
    repeat (5) beat(1, 0);
    beat(1, 1);
    repeat (11) beat(1, 0);
    idle(25);
    frame_checks("resync");
    chk("resync_sync", t_sync, 1);
    chk("resync_bv_total", t_bv, 27);

    // Reset asserted during flush
    clear_tally();
    beat(1, 1);
    repeat (11) beat(1, 0);
    idle(3);
    @(posedge clk);
    #1;
    rst = 0;
    #1;
    chk("midrst_ready", int'(cam_ready), 0);
    chk("midrst_bv", int'(buf_valid), 0);
    chk("midrst_edge", int'(buf_edge), 0);
    chk("midrst_pix", int'(buf_pix), 0);
    chk("midrst_wv", int'(win_valid), 0);
    chk("midrst_wpos", int'({win_border, win_row, win_col}), 0);
    chk("midrst_fd_sync", int'({frame_done, sync_err}), 0);
    repeat (2) @(negedge clk);
    rst = 1;
    #1;
    chk("release_ready_low", int'(cam_ready), 0);
    @(posedge clk);
    #1;
    chk("release_ready_high", int'(cam_ready), 1);
    idle(20);
    chk("midrst_no_fd", t_fd, 0);
    clear_tally();
    beat(1, 1);
    repeat (11) beat(1, 0);
    idle(25);
    frame_checks("postrst");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish, got no end, expected end");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/window_seq_ctrl.md
# window_seq_ctrl

Sequencer for the 3x3 line-buffer/window stage. It sits between the camera capture stream and the image line buffer. It accepts one frame of pixels under a valid/ready handshake and generates the buffer's shift strobe, data and line-edge flag. After the last pixel it injects zero-pixel flush shifts so the bottom rows reach the window centre, and it emits per-window qualifiers (valid, centre coordinates, border flag) aligned with the buffer's 3x3 output, plus frame-done and sync-error pulses.

## Interface
- H_ACTIVE, 640, pixels per line (equals line buffer SHIFT_LENGTH)
- V_ACTIVE, 480, lines per frame
- PIX_W, 12, pixel width
- CENTER_LAG, 2*H_ACTIVE+1, shifts between a pixel entering the buffer and that pixel becoming the window centre
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- cam_valid  in  1  input pixel strobe
- cam_sof  in  1  qualifies cam_valid beat as first pixel of a frame
- cam_pix  in  PIX_W  input pixel
- cam_ready  out  1  controller accepts a beat this cycle
- buf_valid  out  1  line buffer shift enable
- buf_edge  out  1  shifted pixel is column 0 of its line
- buf_pix  out  PIX_W  pixel into line buffer
- win_valid  out  1  buffer 3x3 output holds a real window this cycle
- win_border  out  1  window centre lies on row 0, row V_ACTIVE-1, col 0 or col H_ACTIVE-1
- win_col  out  clog2(H_ACTIVE)  centre column
- win_row  out  clog2(V_ACTIVE)  centre row
- frame_done  out  1  one-cycle pulse, frame fully windowed
- sync_err  out  1  one-cycle pulse, cam_sof seen mid-frame

## Operation
- Beat accepted when cam_valid && cam_ready.
- States:
  - IDLE: cam_ready=1. An accepted beat with cam_sof enters STREAM as pixel 0. Beats without cam_sof are dropped; no buf_valid is generated.
  - STREAM: cam_ready=1. Each accepted beat advances the input col/row counters; col wraps at H_ACTIVE-1 and increments row. The beat at col=H_ACTIVE-1, row=V_ACTIVE-1 moves to FLUSH.
  - FLUSH: cam_ready=0. One zero pixel per cycle, buf_valid=1 every cycle, for exactly CENTER_LAG cycles. The column counter keeps wrapping so buf_edge stays periodic. After the last flush shift, go to DONE.
  - DONE: cam_ready=0 for one cycle, then return to IDLE.
- Shift counter counts buf_valid strobes since frame start and saturates at CENTER_LAG.
- Centre counters (win_col/win_row) advance once per buf_valid strobe after the shift counter has reached CENTER_LAG, i.e. from strobe CENTER_LAG+1 onward.
- Exactly H_ACTIVE*V_ACTIVE windows per frame, in raster order.
- win_border is derived from the centre counters.
- cam_sof on an accepted beat in STREAM:
  - sync_err pulses.
  - All counters clear; that beat becomes pixel 0 of a new frame; state stays STREAM.
  - No win_valid is produced for windows of the aborted frame.
- cam_sof during FLUSH/DONE: ignored, since cam_ready=0.

## Timing
- Reset values: cam_ready=0, all other outputs 0, state IDLE. cam_ready rises on the first clk after rst deasserts.
- buf_valid/buf_pix/buf_edge are registered: one cycle after the accepted beat.
- win_valid, win_col, win_row and win_border are registered and appear in the cycle after the buf_valid strobe whose shift completes the window. This aligns them with the buffer's data_matrix.
- frame_done is asserted in the same cycle as the last win_valid of the frame.
- The next frame's cam_sof is accepted no earlier than the cycle after DONE.
- A throughput of one pixel per clock is sustained in STREAM. Gaps in cam_valid produce gaps in buf_valid; the buffer holds its contents during gaps.
- Reset mid-frame: all state is cleared immediately and outputs go to reset values. No frame_done is generated.

## Test plan
All scenarios use H_ACTIVE=4, V_ACTIVE=3, CENTER_LAG=9.

- Continuous frame, sof at cycle 0, cam_valid held high:
  - buf_valid for 21 consecutive cycles (12 data + 9 flush).
  - win_valid for 12 cycles with (row,col) from (0,0) to (2,3).
  - win_border=0 only for (1,1) and (1,2).
  - frame_done on the 12th win_valid.
- buf_edge check: buf_edge=1 on shift strobes 1, 5, 9, 13, 17, 21 and 0 on all others. cam_ready=0 for 10 cycles (9 FLUSH + 1 DONE).
- cam_valid toggling 1/0 in STREAM: buf_valid follows with 1-cycle delay. The window sequence is identical to the continuous case; only timing stretches.
- Beats without cam_sof in IDLE: no buf_valid, no win_valid. Then a sof beat starts the frame normally.
- cam_sof on the 7th beat of a frame: sync_err pulses once. The frame restarts; exactly 12 win_valid follow, the first centred at (0,0).
- rst asserted during FLUSH: all outputs 0 at once. After release, cam_ready=1 one clk later and a fresh frame completes normally.
